// File: rtl/block_acc_pkg.sv
// block_acc_pkg: shared types and width helper for valid_ready_block_accumulator
package block_acc_pkg;

    typedef enum logic {ACCUM, DONE} block_acc_state_t;

    // The total of block_len samples of the given width always fits in this many bits.
    function automatic int acc_width_f(input int width, input int block_len);
        return width + $clog2(block_len);
    endfunction

endpackage

// File: rtl/valid_ready_block_accumulator.sv
// valid_ready_block_accumulator: sums blocks of up to block_len samples from a valid/ready stream
// Ports:
//   clk, rst (asynchronous, active-low)
//   up_valid/up_ready/up_data/up_last   sample stream in; up_last closes a block early
//   down_valid/down_ready/down_data/down_count   one total plus sample count per block
//   down_max   largest sample of the block (only with BLOCK_ACC_MAX_TRACK_EN defined)
module valid_ready_block_accumulator
    import block_acc_pkg::*;
#(
    parameter int width = 8,
    parameter int block_len = 4,
    localparam int acc_width = acc_width_f(width, block_len),
    localparam int cnt_width = $clog2(block_len + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [width-1:0]     up_data,
    input  logic                 up_last,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic [acc_width-1:0] down_data,
    output logic [cnt_width-1:0] down_count
`ifdef BLOCK_ACC_MAX_TRACK_EN
    ,
    output logic [width-1:0]     down_max
`endif
);

    if (block_len < 2) begin : g_bad_block_len
        $error("block_len must be >= 2");
    end

    block_acc_state_t state, state_next;
    logic [acc_width-1:0] acc, sum;
    logic [cnt_width-1:0] cnt, cnt_inc;
    logic [width-1:0] din;
    logic in_hs, out_hs, close;

    // In DONE any accepted sample starts a fresh block, so the running
    // accumulator is ignored and the sample is summed onto zero.
    always_comb begin
        up_ready = state == ACCUM ? 1'b1 : down_ready;
        down_valid = state == DONE;
        in_hs = up_valid & up_ready;
        out_hs = down_valid & down_ready;
        din = in_hs ? up_data : '0;
        sum = (state == DONE ? '0 : acc) + acc_width'(din);
        cnt_inc = (state == DONE ? '0 : cnt) + cnt_width'(1);
        close = in_hs & (up_last | cnt_inc == cnt_width'(block_len));
        state_next = close ? DONE : (in_hs | out_hs) ? ACCUM : state;
    end

`ifdef BLOCK_ACC_MAX_TRACK_EN
    logic [width-1:0] mx, mx_base, mx_new;
    always_comb begin
        mx_base = state == DONE ? '0 : mx;
        mx_new = din > mx_base ? din : mx_base;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ACCUM;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
            down_data <= '0;
            down_count <= '0;
`ifdef BLOCK_ACC_MAX_TRACK_EN
            mx <= '0;
            down_max <= '0;
`endif
        end else if (close) begin
            down_data <= sum;
            down_count <= cnt_inc;
            acc <= '0;
            cnt <= '0;
`ifdef BLOCK_ACC_MAX_TRACK_EN
            down_max <= mx_new;
            mx <= '0;
`endif
        end else if (in_hs) begin
            acc <= sum;
            cnt <= cnt_inc;
`ifdef BLOCK_ACC_MAX_TRACK_EN
            mx <= mx_new;
`endif
        end
    end

endmodule

// File: doc/valid_ready_block_accumulator.md
Name: valid_ready_block_accumulator

Overview:
- Consumer stage that sits directly downstream of the a+b sum FIFO and takes its sum_valid / sum_ready / sum_data stream.
- Adds block_len consecutive samples, or fewer if the upstream marks the last sample with up_last.
- Emits one widened total plus a sample count per block on a valid/ready output.
- Sustains one sample per clock with no bubble between blocks.

Parameters:
- width, 8, bit width of each input sample (matches the sum FIFO data width).
- block_len, 4, samples per full block; must be >= 2 (elaboration-time assertion).
- Derived localparam acc_width = width + $clog2(block_len): output total width, which cannot overflow.
- Derived localparam cnt_width = $clog2(block_len + 1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock domain, reset is asynchronous and active-low.
- up_valid  input  1  input sample valid.
- up_ready  output  1  block can take the sample.
- up_data  input  width  sample value, unsigned.
- up_last  input  1  marks the sample as the last of the block; only meaningful while up_valid is high.
- down_valid  output  1  result valid.
- down_ready  input  1  downstream can take the result.
- down_data  output  acc_width  block total.
- down_count  output  cnt_width  number of samples in the block (1..block_len).

Behaviour:
- Reset (rst low, async assert, sync deassert):
  - state=ACCUM; acc=0; cnt=0.
  - down_valid=0; down_data=0; down_count=0.
  - up_ready is 1 on the first clock after reset.
- An input handshake is up_valid & up_ready; an output handshake is down_valid & down_ready.
- State ACCUM: up_ready=1, down_valid=0.
  - On an input handshake, if cnt+1==block_len or up_last=1, go to DONE:
    - down_data <= acc + up_data (zero-extended to acc_width); down_count <= cnt+1.
    - acc <= 0; cnt <= 0.
  - On any other input handshake: acc <= acc + up_data; cnt <= cnt+1.
- State DONE: down_valid=1; up_ready=down_ready. This combinational path from down_ready to up_ready is intentional.
  - down_data and down_count are held stable while down_valid=1 and down_ready=0.
  - Output handshake without an input handshake: go to ACCUM.
  - Output handshake with an input handshake (back-to-back): the sample starts a new block.
    - If that sample closes the block (up_last=1, the block is done at 1 sample): stay in DONE; down_data <= zero-extended up_data; down_count <= 1.
    - Otherwise: go to ACCUM with acc <= up_data, cnt <= 1.
- Latency: the result is valid the cycle after the closing input handshake.
- Throughput: 1 sample per clock, including across block boundaries, while down_ready=1.
- Arithmetic is unsigned and cannot overflow: max total is block_len*(2^width - 1), which fits in acc_width.
- up_last is ignored when up_valid=0. up_last=1 on sample index block_len-1 is the same as a full block (count=block_len).
- Reset mid-block discards the partial accumulation and any pending result.
- up_data and up_last may be X while up_valid=0; the datapath must not propagate them.

Optional Feature:
- Macro: BLOCK_ACC_MAX_TRACK_EN.
- When defined:
  - Extra output port down_max (width bits): the maximum sample in the block.
  - Registered alongside down_data and held with it.
  - Reset value 0; max is reset to the first sample of each new block.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package block_acc_pkg holds:
  - typedef enum logic {ACCUM, DONE} block_acc_state_t.
  - function acc_width_f(width, block_len) for reuse by the testbench scoreboard.
- No sub-module is needed; a single module is preferred (about 150 lines).

Test Plan (width=8, block_len=4):
- Full block: stream 10, 20, 30, 40 with down_ready=1 -> one result, down_data=100, down_count=4, one cycle after the 4th handshake.
- Early close: stream 255, 255 with up_last on the 2nd -> down_data=510, down_count=2. Then stream 255 x4 -> down_data=1020 (no overflow).
- Backpressure: hold down_ready=0 after a block completes -> up_ready=0 and the output is stable for 5 cycles. Raise down_ready while up_valid=1 with 7 -> result consumed, and 7 starts the next block.
- Back-to-back: continuous up_valid with 1..12, down_ready=1 -> results 10, 26, 42 with no idle input cycles.
- Single-sample block in DONE: result pending, handshake 9 with up_last=1 -> down_valid stays 1, next output is 9 with count 1.
- Reset mid-block: after 3 samples, pulse rst low -> down_valid=0 immediately. Next block 1, 1, 1, 1 -> down_data=4.
